vga_scroll_pattern: RTL and testbench

- Frame-synchronous scrolling test-pattern generator for the TinyVGA PMOD path, placed between the hvsync timing generator and the output pin mux.
- Runs on the pixel clock and advances once per frame on a single-cycle frame_tick; it has no logic clocked by vsync.
- Parametrised successor to the single-axis bounce scroller. Adds mode select, pause, two-axis offsets, configurable speed limits, and registered, sync-aligned colour outputs.

---
 rtl/vga_scroll_pattern.sv | 161 ++++++++++++++++
 tb/tb_vga_scroll_pattern.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scroll_pattern.sv
// Frame-synchronous scrolling test-pattern generator for the TinyVGA PMOD path.
// Sits between the hvsync timing generator and the output pin mux; everything
// runs on the pixel clock and per-frame state advances on a one-cycle frame_tick.
module vga_scroll_pattern #(
    parameter int unsigned POS_W   = 10,
    parameter int unsigned SPEED_W = 6,
    parameter int          SPD_MAX = 20,
    parameter int          SPD_MIN = -10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_tick,
    input  logic                      video_active,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic [POS_W-1:0]          pix_x,
    input  logic [POS_W-1:0]          pix_y,
    input  logic [1:0]                mode,
    input  logic                      pause,
    output logic [1:0]                r_out,
    output logic [1:0]                g_out,
    output logic [1:0]                b_out,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic [POS_W-1:0]          x_off,
    output logic [POS_W-1:0]          y_off,
    output logic signed [SPEED_W-1:0] speed
);

    // Sign-extension width from the speed register to the offset width.
    localparam int unsigned EXT_W = POS_W - SPEED_W;

    localparam logic [1:0] MODE_STATIC    = 2'b00;
    localparam logic [1:0] MODE_SCROLL    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE_X  = 2'b10;
    localparam logic [1:0] MODE_BOUNCE_XY = 2'b11;

    localparam logic signed [SPEED_W-1:0] SPD_MAX_S = SPEED_W'(SPD_MAX);
    localparam logic signed [SPEED_W-1:0] SPD_MIN_S = SPEED_W'(SPD_MIN);
    localparam logic signed [SPEED_W-1:0] SPD_ONE   = SPEED_W'(1);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    dir_t                      dir;
    logic                      frame_step;
    logic                      bounce_mode;
    logic signed [SPEED_W-1:0] speed_half;
    logic [POS_W-1:0]          speed_ext;
    logic [POS_W-1:0]          half_ext;
    logic [POS_W-1:0]          mx;
    logic [POS_W-1:0]          my;
    logic                      unused_coord_bits;

    // A frame update happens only on an unpaused tick.
    assign frame_step  = frame_tick & ~pause;
    assign bounce_mode = (mode == MODE_BOUNCE_X) || (mode == MODE_BOUNCE_XY);

    // Pre-update speed and its arithmetic half, sign-extended to offset width.
    always_comb begin
        speed_half = speed >>> 1;
        speed_ext  = {{EXT_W{speed[SPEED_W-1]}}, speed};
        half_ext   = {{EXT_W{speed_half[SPEED_W-1]}}, speed_half};
    end

    // Bounce FSM: speed ramps toward SPD_MAX, turns, ramps toward SPD_MIN, turns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir   <= DIR_UP;
            speed <= '0;
        end else if (frame_step && bounce_mode) begin
            case (dir)
                DIR_UP: begin
                    if (speed >= SPD_MAX_S) begin
                        dir   <= DIR_DOWN;
                        speed <= speed - SPD_ONE;
                    end else begin
                        speed <= speed + SPD_ONE;
                    end
                end
                DIR_DOWN: begin
                    if (speed <= SPD_MIN_S) begin
                        dir   <= DIR_UP;
                        speed <= speed + SPD_ONE;
                    end else begin
                        speed <= speed - SPD_ONE;
                    end
                end
                default: begin
                    dir   <= DIR_UP;
                    speed <= '0;
                end
            endcase
        end
    end

    // Scroll offsets; the modulo wrap falls out of the fixed register width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_off <= '0;
            y_off <= '0;
        end else if (frame_step) begin
            case (mode)
                MODE_STATIC: begin
                end
                MODE_SCROLL: begin
                    x_off <= x_off + POS_W'(1);
                end
                MODE_BOUNCE_X: begin
                    x_off <= x_off + speed_ext;
                end
                MODE_BOUNCE_XY: begin
                    x_off <= x_off + speed_ext;
                    y_off <= y_off + half_ext;
                end
                default: begin
                end
            endcase
        end
    end

    // Pattern coordinates use the offsets as they stand before any tick this cycle.
    always_comb begin
        mx = pix_x + x_off;
        my = pix_y + y_off;
    end

    // Coordinate bits the pattern does not look at.
    assign unused_coord_bits = ^{mx[4:0], mx[POS_W-1:8], my[1:0], my[4:3], my[POS_W-1:6]};

    // Registered colour, blanked outside the active area.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= 2'b00;
            g_out <= 2'b00;
            b_out <= 2'b00;
        end else if (video_active) begin
            r_out <= {mx[5], my[2]};
            g_out <= {mx[6], my[2]};
            b_out <= {mx[7], my[5]};
        end else begin
            r_out <= 2'b00;
            g_out <= 2'b00;
            b_out <= 2'b00;
        end
    end

    // Syncs take the same one-cycle delay as the colour so the pins stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
        end
    end

endmodule

// File: tb/tb_vga_scroll_pattern.sv
// Scoreboard bench for vga_scroll_pattern: the stimulus process queues the
// expected post-edge outputs from an integer reference model; a monitor pops
// and compares one entry per clock while reset is released.
module tb_vga_scroll_pattern;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       video_active = 1'b0;
    logic       hsync_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic [1:0] mode = 2'b00;
    logic       pause = 1'b0;
    logic [1:0] r_out, g_out, b_out;
    logic       hsync_out, vsync_out;
    logic [9:0] x_off, y_off;
    logic [5:0] speed;

    vga_scroll_pattern dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .video_active(video_active), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pix_x(pix_x), .pix_y(pix_y), .mode(mode), .pause(pause),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .x_off(x_off), .y_off(y_off), .speed(speed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r, g, b, hs, vs, x, y, spd;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: offsets as integers in [0,1024), speed as a plain int.
    int m_x = 0, m_y = 0, m_spd = 0;
    bit m_up = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wrap(input int v);
        return ((v % 1024) + 1024) % 1024;
    endfunction

    function automatic int bit_of(input int v, input int n);
        return (v >> n) & 1;
    endfunction

    function automatic int floor_half(input int v);
        return (v >= 0) ? v / 2 : -((1 - v) / 2);
    endfunction

    function automatic int sdut(input logic [5:0] v);
        return int'($signed(v));
    endfunction

    // Apply one unpaused frame tick in the given mode.
    task automatic model_tick(input int md);
        int old;
        old = m_spd;
        if (md == 1) m_x = wrap(m_x + 1);
        if (md >= 2) begin
            m_x = wrap(m_x + old);
            if (md == 3) m_y = wrap(m_y + floor_half(old));
            if (m_up) begin
                if (old >= 20) begin m_up = 1'b0; m_spd = old - 1; end
                else m_spd = old + 1;
            end else begin
                if (old <= -10) begin m_up = 1'b1; m_spd = old + 1; end
                else m_spd = old - 1;
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the expected result.
    task automatic step(input bit tk, input int md, input bit ps, input bit act,
                        input bit hs, input bit vs, input int px, input int py);
        exp_t e;
        int   mx, my;
        @(negedge clk);
        rst_n        = 1'b1;
        frame_tick   = tk;
        mode         = 2'(md);
        pause        = ps;
        video_active = act;
        hsync_in     = hs;
        vsync_in     = vs;
        pix_x        = 10'(px);
        pix_y        = 10'(py);
        mx = wrap(px + m_x);
        my = wrap(py + m_y);
        e.r  = act ? bit_of(mx, 5) * 2 + bit_of(my, 2) : 0;
        e.g  = act ? bit_of(mx, 6) * 2 + bit_of(my, 2) : 0;
        e.b  = act ? bit_of(mx, 7) * 2 + bit_of(my, 5) : 0;
        e.hs = hs;
        e.vs = vs;
        if (tk && !ps) model_tick(md);
        e.x   = m_x;
        e.y   = m_y;
        e.spd = m_spd;
        sbq.push_back(e);
    endtask

    task automatic rand_step(input bit tk, input int md, input bit ps);
        step(tk, md, ps, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 1023), $urandom_range(0, 1023));
    endtask

    // One frame: a few idle pixel cycles followed by the tick cycle.
    task automatic tick_frame(input int md, input bit ps);
        repeat (3) rand_step(1'b0, md, 1'b0);
        rand_step(1'b1, md, ps);
    endtask

    // Assert reset between edges; outputs must clear without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("rst_rgb", int'({r_out, g_out, b_out}), 0);
        chk("rst_hsync", int'(hsync_out), 0);
        chk("rst_vsync", int'(vsync_out), 0);
        chk("rst_x_off", int'(x_off), 0);
        chk("rst_y_off", int'(y_off), 0);
        chk("rst_speed", sdut(speed), 0);
        m_x = 0; m_y = 0; m_spd = 0; m_up = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one queued expectation per clock edge outside reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty: no expectation queued at %0t", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_r", int'(r_out), e.r);
                    chk("sb_g", int'(g_out), e.g);
                    chk("sb_b", int'(b_out), e.b);
                    chk("sb_hsync", int'(hsync_out), e.hs);
                    chk("sb_vsync", int'(vsync_out), e.vs);
                    chk("sb_x_off", int'(x_off), e.x);
                    chk("sb_y_off", int'(y_off), e.y);
                    chk("sb_speed", sdut(speed), e.spd);
                end
            end
        end
    end

    initial begin
        int n, ex, ey, sp;
        bit ps;

        // Bounce X from reset: ramp to 20, turn, ramp down.
        do_reset();
        for (int k = 1; k <= 35; k++) begin
            tick_frame(2, 1'b0);
            if (k == 21) begin
                after_edge();
                chk("bounce_x_after_21", int'(x_off), 210);
                chk("bounce_spd_after_21", sdut(speed), 19);
            end
        end
        after_edge();
        chk("bounce_spd_after_35", sdut(speed), 5);

        // Run down to the lower turning point, then turn back up.
        n = 0;
        while (m_spd != -10 && n < 200) begin
            tick_frame(2, 1'b0);
            n++;
        end
        after_edge();
        chk("reach_spd_min", sdut(speed), -10);
        tick_frame(2, 1'b0);
        after_edge();
        chk("turn_at_min", sdut(speed), -9);
        tick_frame(2, 1'b0);
        after_edge();
        chk("up_after_min", sdut(speed), -8);

        // Ramp to -3, then one bounce-XY tick.
        repeat (5) tick_frame(2, 1'b0);
        after_edge();
        chk("preload_spd", sdut(speed), -3);
        ex = m_x;
        ey = m_y;
        tick_frame(3, 1'b0);
        after_edge();
        chk("xy_x_minus3", int'(x_off), wrap(ex - 3));
        chk("xy_y_minus2", int'(y_off), wrap(ey - 2));

        // Constant scroll with pause toggling; speed must not move.
        sp = m_spd;
        for (int k = 0; k < 16; k++) begin
            ps = 1'($urandom_range(0, 1));
            tick_frame(1, ps);
        end
        ex = m_x;
        tick_frame(1, 1'b1);
        after_edge();
        chk("paused_tick_x", int'(x_off), ex);
        chk("scroll_spd_held", sdut(speed), sp);

        // Colour at x_off = 0x20.
        do_reset();
        repeat (32) tick_frame(1, 1'b0);
        step(1'b0, 1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 4);
        after_edge();
        chk("colour_x_off", int'(x_off), 32);
        chk("colour_r", int'(r_out), 3);
        chk("colour_g", int'(g_out), 1);
        chk("colour_b", int'(b_out), 0);
        chk("colour_hsync", int'(hsync_out), 1);
        step(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 4);
        after_edge();
        chk("blank_rgb", int'({r_out, g_out, b_out}), 0);
        chk("blank_hsync", int'(hsync_out), 0);
        chk("blank_vsync", int'(vsync_out), 1);

        // Reset in the middle of a bounce.
        do_reset();
        repeat (12) tick_frame(2, 1'b0);
        after_edge();
        chk("pre_reset_spd", sdut(speed), 12);
        do_reset();
        tick_frame(2, 1'b0);
        after_edge();
        chk("post_reset_first_tick", sdut(speed), 1);

        // Randomised frames over all modes with occasional pause.
        for (int k = 0; k < 150; k++) begin
            tick_frame($urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end
        after_edge();
        chk("queue_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
